// File: rtl/wb_stream_dma_writer.sv
// Stream-to-memory DMA: buffers a valid/ready stream in a FIFO and writes it to memory
// as Wishbone incrementing bursts, configured through a 32-bit Wishbone slave.
module wb_stream_dma_writer #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic [WB_DW-1:0]   stream_s_data_i,
    input  logic               stream_s_valid_i,
    output logic               stream_s_ready_o,
    output logic               irq_o,
    input  logic [4:0]         wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic               wbs_we_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic [2:0]         wbs_cti_i,
    input  logic [1:0]         wbs_bte_i,
    output logic [31:0]        wbs_dat_o,
    output logic               wbs_ack_o,
    output logic               wbs_err_o
);
    localparam int          WSB    = WB_DW / 8;
    localparam int          WSB_LG = $clog2(WSB);
    localparam int          CW     = FIFO_AW + 1;
    localparam logic [31:0] MAX_BL = 32'(MAX_BURST_LEN);
    localparam logic [31:0] WSB32  = 32'(WSB);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, CHECK} state_t;
    state_t state, state_nxt;

    logic        en, irq, circ, busy, err;
    logic [31:0] start_addr, buf_size, burst_len, wr_ptr;
    logic [31:0] size_al, remaining, rem_words, blen_eff, beats_cmb;
    logic [31:0] beats_lat, beat_cnt, rd_mux;

    logic [WB_DW-1:0]   fifo_mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] rd_ptr, wt_ptr;
    logic [CW-1:0]      count;
    logic               fifo_full, push, pop, flush;
    logic               wbs_req, mapped, wbs_wr, csr_wr, start;
    logic               beat_ok, beat_err, last_beat;

    logic unused_inputs;
    assign unused_inputs = ^{wbm_dat_i, wbs_sel_i, wbs_cti_i, wbs_bte_i, wbs_adr_i[1:0]};

    assign size_al   = buf_size & ~(WSB32 - 32'd1);
    assign remaining = size_al - wr_ptr;
    assign rem_words = remaining >> WSB_LG;

    always_comb begin
        blen_eff = burst_len;
        if (burst_len == 32'd0)
            blen_eff = 32'd1;
        else if (burst_len > MAX_BL)
            blen_eff = MAX_BL;
    end

    assign beats_cmb = (rem_words < blen_eff) ? rem_words : blen_eff;

    assign fifo_full        = count == CW'(2**FIFO_AW);
    assign stream_s_ready_o = ~fifo_full;
    assign push             = stream_s_valid_i & ~fifo_full;
    // An ack that arrives together with err is treated purely as an error: nothing is popped.
    assign beat_ok          = (state == BURST) & wbm_ack_i & ~wbm_err_i;
    assign beat_err         = (state == BURST) & wbm_err_i;
    assign pop              = beat_ok;
    assign last_beat        = beat_cnt == beats_lat - 32'd1;

    assign wbs_req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
    assign mapped  = wbs_adr_i[4:2] <= 3'd4;
    assign wbs_wr  = wbs_req & mapped & wbs_we_i;
    assign csr_wr  = wbs_wr & (wbs_adr_i[4:2] == 3'd0);
    assign start   = csr_wr & wbs_dat_i[0] & (state == IDLE);
    assign flush   = start & (size_al != 32'd0);
    assign irq_o   = irq;

    always_comb begin
        rd_mux = '0;
        case (wbs_adr_i[4:2])
            3'd0:    rd_mux = {27'd0, err, busy, circ, irq, en};
            3'd1:    rd_mux = start_addr;
            3'd2:    rd_mux = buf_size;
            3'd3:    rd_mux = burst_len;
            3'd4:    rd_mux = wr_ptr;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wbs_req & mapped;
            wbs_err_o <= wbs_req & ~mapped;
            if (wbs_req && mapped && !wbs_we_i)
                wbs_dat_o <= rd_mux;
        end
    end

    // Flush keeps a word pushed in the same cycle so an accepted handshake is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wt_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wt_ptr <= FIFO_AW'(push);
            count  <= CW'(push);
        end else begin
            if (push)
                wt_ptr <= wt_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[flush ? '0 : wt_ptr] <= stream_s_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (flush) state_nxt = WAIT;
            WAIT:  if (!en) state_nxt = IDLE;
                   else if (32'(count) >= beats_cmb) state_nxt = BURST;
            BURST: if (beat_err) state_nxt = IDLE;
                   else if (beat_ok && last_beat) state_nxt = CHECK;
            CHECK: if (remaining == 32'd0) state_nxt = (circ && en) ? WAIT : IDLE;
                   else state_nxt = en ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = '0;
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        wbm_cti_o = 3'b000;
        if (state == BURST) begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_we_o  = 1'b1;
            wbm_sel_o = '1;
            wbm_adr_o = WB_AW'(start_addr + wr_ptr);
            wbm_dat_o = fifo_mem[rd_ptr];
            wbm_cti_o = last_beat ? 3'b111 : 3'b010;
        end
    end
    assign wbm_bte_o = 2'b00;

    // Bus-side events are applied after the CSR write so they win on a same-cycle conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en         <= 1'b0;
            irq        <= 1'b0;
            circ       <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            start_addr <= '0;
            buf_size   <= '0;
            burst_len  <= '0;
            wr_ptr     <= '0;
            beats_lat  <= '0;
            beat_cnt   <= '0;
        end else begin
            if (csr_wr) begin
                en   <= wbs_dat_i[0];
                circ <= wbs_dat_i[2];
                if (wbs_dat_i[1]) irq <= 1'b0;
                if (wbs_dat_i[4]) err <= 1'b0;
            end
            if (wbs_wr && !busy) begin
                case (wbs_adr_i[4:2])
                    3'd1:    start_addr <= wbs_dat_i;
                    3'd2:    buf_size   <= wbs_dat_i;
                    3'd3:    burst_len  <= wbs_dat_i;
                    default: ;
                endcase
            end
            if (start) begin
                if (size_al == 32'd0) begin
                    irq <= 1'b1;
                    en  <= 1'b0;
                end else begin
                    busy   <= 1'b1;
                    wr_ptr <= '0;
                end
            end
            if (state == WAIT && !en)
                busy <= 1'b0;
            if (state == WAIT && state_nxt == BURST) begin
                beats_lat <= beats_cmb;
                beat_cnt  <= '0;
            end
            if (beat_ok) begin
                wr_ptr   <= wr_ptr + WSB32;
                beat_cnt <= beat_cnt + 32'd1;
            end
            if (beat_err) begin
                err  <= 1'b1;
                irq  <= 1'b1;
                en   <= 1'b0;
                busy <= 1'b0;
            end
            if (state == CHECK) begin
                if (remaining == 32'd0) begin
                    irq <= 1'b1;
                    if (circ && en) begin
                        wr_ptr <= '0;
                    end else begin
                        en   <= 1'b0;
                        busy <= 1'b0;
                    end
                end else if (!en) begin
                    busy <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_stream_dma_writer.sv
// Bench for wb_stream_dma_writer: random stream data and memory wait states, with a
// word-level address/burst model feeding a scoreboard checked by a bus monitor.
module tb_wb_stream_dma_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
    logic [31:0] stream_s_data_i = '0;
    logic        stream_s_valid_i = 1'b0, stream_s_ready_o, irq_o;
    logic [4:0]  wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0, wbs_dat_o;
    logic        wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0;
    logic        wbs_ack_o, wbs_err_o;

    always #5 clk = ~clk;

    wb_stream_dma_writer dut (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(32'd0),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .stream_s_data_i(stream_s_data_i), .stream_s_valid_i(stream_s_valid_i),
        .stream_s_ready_o(stream_s_ready_o), .irq_o(irq_o),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(4'hF),
        .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_cti_i(3'b000), .wbs_bte_i(2'b00),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       cap, mon_e;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] sent_q[$];
    int          checks = 0, errors = 0;
    logic [31:0] m_start;
    int          m_size, m_b, m_k, m_limit;
    bit          m_circ;
    int          beat_no = 0, err_beat = -1;
    bit          hold_ack = 1'b0, ack_pending = 1'b0, err_pending = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Word k of a transfer lands at word (k mod N) of the buffer; bursts are cut every
    // m_b words from the buffer start and at the buffer end.
    function automatic void model_word(input logic [31:0] d);
        int    n, i;
        beat_t e;
        n = m_size / 4;
        if (m_k < m_limit && (m_circ || m_k < n)) begin
            i     = m_k % n;
            e.adr = m_start + 32'(4 * i);
            e.dat = d;
            e.cti = ((i % m_b) == m_b - 1 || i == n - 1) ? 3'b111 : 3'b010;
            exp_q.push_back(e);
        end
        m_k++;
    endfunction

    // Memory slave with random wait states plus the beat monitor.
    always @(negedge clk) begin
        if (ack_pending) begin
            beat_no++;
            mem[cap.adr] = cap.dat;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: adr 0x%0h data 0x%0h, no beat expected", cap.adr, cap.dat);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_adr", 64'(cap.adr), 64'(mon_e.adr));
                chk("beat_dat", 64'(cap.dat), 64'(mon_e.dat));
                chk("beat_cti", 64'(cap.cti), 64'(mon_e.cti));
            end
        end
        if (err_pending) begin
            chk("cyc_drop_after_err", 64'(wbm_cyc_o), 64'd0);
            err_pending = 1'b0;
        end
        ack_pending = 1'b0;
        wbm_ack_i   = 1'b0;
        wbm_err_i   = 1'b0;
        if (rst_n && wbm_cyc_o && wbm_stb_o && !hold_ack) begin
            chk("beat_ctl", 64'({wbm_sel_o, wbm_we_o, wbm_bte_o}), 64'({4'hF, 1'b1, 2'b00}));
            if (beat_no == err_beat) begin
                wbm_err_i   = 1'b1;
                wbm_ack_i   = 1'($urandom_range(0, 1));
                err_pending = 1'b1;
                err_beat    = -1;
            end else if ($urandom_range(0, 3) != 0) begin
                wbm_ack_i   = 1'b1;
                ack_pending = 1'b1;
                cap.adr     = wbm_adr_o;
                cap.dat     = wbm_dat_o;
                cap.cti     = wbm_cti_o;
            end
        end
    end

    task automatic wb_access(input logic [4:0] a, input logic [31:0] d, input bit we,
                             output logic [31:0] rd, output logic e, output logic k);
        int n = 0;
        wbs_adr_i = a; wbs_dat_i = d; wbs_we_i = we; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        @(posedge clk); #1;
        while (!(wbs_ack_o || wbs_err_o) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL wbs_timeout: no ack/err at 0x%0h after %0d cycles, expected one", a, n);
        end
        rd = wbs_dat_o; e = wbs_err_o; k = wbs_ack_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        e, k;
        wb_access(a, d, 1'b1, rd, e, k);
    endtask

    task automatic wb_read(input logic [4:0] a, output logic [31:0] rd);
        logic e, k;
        wb_access(a, 32'd0, 1'b0, rd, e, k);
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] d;
            int          t;
            d = $urandom;
            t = 0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            stream_s_valid_i = 1'b1;
            stream_s_data_i  = d;
            while (!stream_s_ready_o && t < 1000) begin @(posedge clk); #1; t++; end
            if (t >= 1000) begin
                checks++;
                errors++;
                $display("FAIL stream_stall: ready low for %0d cycles, expected high", t);
            end
            @(posedge clk); #1;
            stream_s_valid_i = 1'b0;
            sent_q.push_back(d);
            model_word(d);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || wbm_cyc_o) && n < 3000) begin @(posedge clk); #1; n++; end
        chk("drain_pending_beats", 64'(exp_q.size()), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic cfg(input logic [31:0] st, input int sz, input int bl, input bit circ, input int lim);
        wb_write(5'h04, st);
        wb_write(5'h08, 32'(sz));
        wb_write(5'h0C, 32'(bl));
        m_start = st; m_size = sz; m_circ = circ; m_k = 0; m_limit = lim;
        m_b = (bl == 0) ? 1 : ((bl > 16) ? 16 : bl);
        beat_no = 0;
        sent_q.delete();
        exp_q.delete();
        wb_write(5'h00, circ ? 32'h5 : 32'h1);
    endtask

    task automatic xfer(input string nm, input logic [31:0] st, input int sz, input int bl,
                        input bit circ, input int nw, input logic [31:0] exp_csr,
                        input logic [31:0] exp_ptr);
        logic [31:0] rd;
        cfg(st, sz, bl, circ, 1 << 30);
        send(nw);
        drain();
        wb_read(5'h00, rd);
        chk($sformatf("%s_csr", nm), 64'(rd), 64'(exp_csr));
        wb_read(5'h10, rd);
        chk($sformatf("%s_wr_ptr", nm), 64'(rd), 64'(exp_ptr));
        chk($sformatf("%s_irq", nm), 64'(irq_o), 64'd1);
        if (circ) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("%s_mem%0d", nm, i), 64'(mem[st + 32'(4 * i)]), 64'(sent_q[nw - 4 + i]));
        end
        wb_write(5'h00, 32'h2);
        @(posedge clk); #1;
        wb_read(5'h00, rd);
        chk($sformatf("%s_csr_cleared", nm), 64'(rd), 64'd0);
        chk($sformatf("%s_irq_cleared", nm), 64'(irq_o), 64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e, k;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 64'(wbm_cyc_o), 64'd0);
        chk("rst_irq", 64'(irq_o), 64'd0);
        chk("rst_wbs_ack", 64'(wbs_ack_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read(5'h00, rd);
        chk("rst_csr", 64'(rd), 64'd0);

        xfer("two_bursts",  32'h40,  32'h20, 4,   1'b0, 8,  32'h2, 32'h20);
        xfer("partial",     32'h80,  32'h1C, 4,   1'b0, 7,  32'h2, 32'h1C);
        xfer("burst1",      32'hC0,  32'h0C, 1,   1'b0, 3,  32'h2, 32'h0C);
        xfer("burst0",      32'hE0,  32'h08, 0,   1'b0, 2,  32'h2, 32'h08);
        xfer("clamped",     32'h400, 32'h48, 100, 1'b0, 18, 32'h2, 32'h48);
        xfer("circular",    32'h100, 32'h10, 2,   1'b1, 12, 32'hF, 32'h0);

        // Zero-size start: irq immediately, en cleared, no bus traffic.
        wb_write(5'h08, 32'h0);
        wb_write(5'h00, 32'h1);
        repeat (5) begin @(posedge clk); #1; end
        wb_read(5'h00, rd);
        chk("size0_csr", 64'(rd), 64'h2);
        wb_write(5'h00, 32'h2);

        // Bus error on the third beat of the first burst.
        cfg(32'h200, 32'h20, 4, 1'b0, 2);
        err_beat = 2;
        send(8);
        n = 0;
        while ((err_beat != -1 || err_pending || wbm_cyc_o) && n < 2000) begin @(posedge clk); #1; n++; end
        repeat (3) begin @(posedge clk); #1; end
        wb_read(5'h00, rd);
        chk("err_csr", 64'(rd), 64'h12);
        chk("err_irq", 64'(irq_o), 64'd1);
        chk("err_pending_beats", 64'(exp_q.size()), 64'd0);
        n = 0;
        while (stream_s_ready_o && n < 64) begin
            stream_s_valid_i = 1'b1;
            stream_s_data_i  = $urandom;
            @(posedge clk); #1;
            n++;
        end
        stream_s_valid_i = 1'b0;
        chk("err_fifo_free_slots", 64'(n), 64'd26);
        wb_write(5'h00, 32'h12);
        wb_read(5'h00, rd);
        chk("err_csr_cleared", 64'(rd), 64'd0);
        chk("err_irq_cleared", 64'(irq_o), 64'd0);

        // Reset pulse in the middle of a stalled burst.
        hold_ack = 1'b1;
        cfg(32'h300, 32'h10, 4, 1'b0, 0);
        send(4);
        n = 0;
        while (!wbm_cyc_o && n < 200) begin @(posedge clk); #1; n++; end
        chk("rstmid_burst_started", 64'(wbm_cyc_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_cyc", 64'(wbm_cyc_o), 64'd0);
        chk("rstmid_stb", 64'(wbm_stb_o), 64'd0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        hold_ack = 1'b0;
        wb_read(5'h00, rd);
        chk("rstmid_csr", 64'(rd), 64'd0);
        wb_access(5'h14, 32'd0, 1'b0, rd, e, k);
        chk("unmapped_err", 64'(e), 64'd1);
        chk("unmapped_ack", 64'(k), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_stream_dma_writer.md
Name: wb_stream_dma_writer

Overview:
Parametrised stream-to-memory DMA. It buffers a valid/ready input stream in an internal FIFO and writes it to memory as Wishbone incrementing bursts, under the control of a 32-bit Wishbone config slave. It supersedes the fixed-function stream reader and adds:
- a partial final burst (buffer size need not be a multiple of the burst length);
- burst length 1;
- circular (ring-buffer) mode;
- bus-error reporting;
- a readable progress pointer.

Parameters:
WB_AW, 32, data-master address width
WB_DW, 32, data-master/stream width (32 or 64); WSB = WB_DW/8
FIFO_AW, 5, FIFO depth 2^FIFO_AW words
MAX_BURST_LEN, 16, max beats per burst; must be <= 2^FIFO_AW

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wbm_adr_o  out  WB_AW  memory address (byte)
wbm_dat_o  out  WB_DW  write data
wbm_sel_o  out  WSB  byte select, all ones
wbm_we_o  out  1  always 1 while cyc
wbm_cyc_o  out  1  cycle
wbm_stb_o  out  1  strobe
wbm_cti_o  out  3  010 incrementing, 111 last beat
wbm_bte_o  out  2  always 00 (linear)
wbm_dat_i  in  WB_DW  unused
wbm_ack_i  in  1  beat accepted
wbm_err_i  in  1  bus error
stream_s_data_i  in  WB_DW  stream data
stream_s_valid_i  in  1  data valid
stream_s_ready_o  out  1  FIFO not full
irq_o  out  1  level interrupt = CSR.irq
wbs_adr_i  in  5  config byte address
wbs_dat_i  in  32  config write data
wbs_sel_i  in  4  ignored (full-word access)
wbs_we_i  in  1  write enable
wbs_cyc_i  in  1  cycle
wbs_stb_i  in  1  strobe
wbs_cti_i  in  3  ignored
wbs_bte_i  in  2  ignored
wbs_dat_o  out  32  read data
wbs_ack_o  out  1  ack
wbs_err_o  out  1  error, unmapped address

Behaviour:
- Reset (async, rst_n low): all outputs 0; registers 0; FIFO empty; FSM IDLE. Assertion mid-burst drops cyc/stb immediately.
- Register map (byte offsets):
  - 0x00 CSR: bit0 en (RW); bit1 irq (W1C); bit2 circ (RW); bit3 busy (RO); bit4 err (W1C).
  - 0x04 START_ADDR.
  - 0x08 BUF_SIZE (bytes; low log2(WSB) bits ignored).
  - 0x0C BURST_LEN (beats; 0 treated as 1; values > MAX_BURST_LEN clamped).
  - 0x10 WR_PTR (RO): bytes written in the current pass.
- Config slave:
  - ack = cyc & stb & ~ack, registered, giving 1-cycle latency with no back-to-back ack.
  - Offsets 0x14-0x1F give err instead of ack; no state changes.
  - Writes to 0x04/0x08/0x0C while busy are ignored, but still acked.
- Start: CSR write with en=1 while IDLE flushes the FIFO, clears WR_PTR, latches config, and sets busy.
  - BUF_SIZE=0: set irq, clear en, no bus traffic.
- FIFO: stream handshake on valid & ready; ready = not full, regardless of en. Simultaneous push and pop in one cycle keep the count unchanged.
- FSM:
  - IDLE -> WAIT on start.
  - WAIT: beats = min(BURST_LEN, remaining/WSB). Go to BURST when FIFO count >= beats.
  - BURST: cyc=stb=1; adr = START_ADDR + WR_PTR; dat = FIFO head; cti=111 on last beat (and on the only beat when beats=1), else 010. Each ack pops the FIFO and adds WSB to WR_PTR. After the last ack, cyc drops the next cycle -> CHECK.
  - CHECK: if remaining=0, set irq. Then:
    - circ=1 and en=1: WR_PTR <- 0, go to WAIT.
    - otherwise: clear en and busy, go to IDLE.
    - remaining > 0: WAIT if en=1, IDLE if en=0.
- Disable mid-burst (en written 0): the current burst completes, then IDLE with no irq.
- wbm_err_i during BURST: drop cyc next cycle; the errored beat is not popped; set err and irq; clear en; IDLE.
  - ack and err together count as err.
- irq re-asserts in circular mode even if not cleared (level stays high).
- Address arithmetic WB_AW bits wraps modulo 2^WB_AW; no other boundary check.

Test Plan:
- WB_DW=32, START=0x40, BUF_SIZE=0x20, BURST=4, stream 8 words -> two 4-beat bursts at 0x40 and 0x50; cti 010,010,010,111; irq high; memory matches; WR_PTR=0x20.
- BUF_SIZE=0x1C, BURST=4 -> bursts of 4 then 3 beats; irq after 7 words; busy=0.
- BURST=1, BUF_SIZE=0x0C -> three single-beat cycles, each with cti=111.
- circ=1, BUF_SIZE=0x10, BURST=2, stream 12 words -> words 9-12 overwrite START..START+0x0C; irq set after word 4; en still 1.
- Memory raises err on beat 3 of burst 1 -> cyc drops; CSR reads 0x12; irq=1; FIFO retains the unwritten words; writing 0x12 to CSR clears irq.
- Reset pulse mid-burst; config read of 0x14 -> cyc low immediately, CSR=0; 0x14 returns wbs_err_o=1, no ack.
